phy_tx_sched: RTL and testbench



---
 rtl/phy_tx_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 58 +++++
 rtl/phy_tx_sched.sv | 133 +++++++++++++
 tb/tb_phy_tx_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_pkg.sv
// Shared link-state encoding, K-symbol constants and saturating counter helpers
// for the phy_tx_sched block.
package phy_tx_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_TRAIN = 2'b01,
    ST_RUN   = 2'b10
  } link_state_e;

  localparam logic [7:0]  COM            = 8'hBC;
  localparam logic [31:0] DEF_TRAIN_WORD = {4{COM}};
  localparam logic [31:0] DEF_IDLE_WORD  = 32'h0000_0000;

  function automatic logic [3:0] satInc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a burst cap; grants are combinational,
// pointer/owner/burst state updates on the rising edge of clk_f.
module rr_arb2
  import phy_tx_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk_f,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic       r_ptr;
  logic       r_owner;
  logic [3:0] r_burst;
  logic       w_gntIdx;
  logic [3:0] w_burstInc;
  logic       w_capHit;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) gnt = r_ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  assign w_gntIdx   = gnt[1];
  assign w_burstInc = (r_owner == w_gntIdx) ? satInc4(r_burst) : 4'd1;
  assign w_capHit   = (w_burstInc >= 4'(MAX_BURST)) && req[~w_gntIdx];

  // An idle cycle breaks the run of consecutive grants, so the burst count clears.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_burst <= 4'd0;
    end else if (!enable) begin
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_burst <= 4'd0;
    end else if (|gnt) begin
      r_owner <= w_gntIdx;
      if (w_capHit) begin
        r_ptr   <= ~w_gntIdx;
        r_burst <= 4'd0;
      end else begin
        r_ptr   <= w_gntIdx;
        r_burst <= w_burstInc;
      end
    end else begin
      r_burst <= 4'd0;
    end
  end

endmodule

// File: rtl/phy_tx_sched.sv
// Link-level TX scheduler: trains the link, then round-robins two requesters onto the phy.
// Optional per-requester grant counters are enabled with `define PHY_TX_SCHED_STATS_EN.
module phy_tx_sched
  import phy_tx_pkg::*;
#(
  parameter int unsigned TRAIN_WORDS = 4,
  parameter logic [31:0] TRAIN_WORD  = DEF_TRAIN_WORD,
  parameter logic [31:0] IDLE_WORD   = DEF_IDLE_WORD,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic        link_en,
  input  logic        req0,
  input  logic [31:0] data0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        gnt1,
  output logic        tx_active,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  output logic [1:0]  link_state
`ifdef PHY_TX_SCHED_STATS_EN
  ,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
`endif
);

  // The entry edge already launches the first training word, hence the minus one.
  localparam logic [7:0] LAST_TRAIN = 8'(TRAIN_WORDS - 1);

  link_state_e r_state, w_nextState;
  logic [7:0]  r_trainCnt, w_nextTrainCnt;
  logic        r_active, r_valid, w_nextValid;
  logic [31:0] r_data, w_nextData;
  logic [1:0]  w_gnt;
  logic        w_arbEn;

  assign w_arbEn = (r_state == ST_RUN) && link_en;

  rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk_f  (clk_f),
    .reset  (reset),
    .enable (w_arbEn),
    .req    ({req1, req0}),
    .gnt    (w_gnt)
  );

  assign gnt0 = w_gnt[0];
  assign gnt1 = w_gnt[1];

  always_comb begin
    w_nextState    = r_state;
    w_nextTrainCnt = r_trainCnt;
    w_nextValid    = 1'b0;
    w_nextData     = IDLE_WORD;
    case (r_state)
      ST_OFF: begin
        w_nextTrainCnt = 8'd0;
        if (link_en) begin
          w_nextState = ST_TRAIN;
          w_nextValid = 1'b1;
          w_nextData  = TRAIN_WORD;
        end
      end
      ST_TRAIN: begin
        if (!link_en) begin
          w_nextState = ST_OFF;
        end else if (r_trainCnt >= LAST_TRAIN) begin
          w_nextState = ST_RUN;
        end else begin
          w_nextTrainCnt = satInc8(r_trainCnt);
          w_nextValid    = 1'b1;
          w_nextData     = TRAIN_WORD;
        end
      end
      ST_RUN: begin
        if (!link_en) begin
          w_nextState = ST_OFF;
        end else if (w_gnt[0]) begin
          w_nextValid = 1'b1;
          w_nextData  = data0;
        end else if (w_gnt[1]) begin
          w_nextValid = 1'b1;
          w_nextData  = data1;
        end
      end
      default: w_nextState = ST_OFF;
    endcase
  end

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_OFF;
      r_trainCnt <= 8'd0;
      r_active   <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= IDLE_WORD;
    end else begin
      r_state    <= w_nextState;
      r_trainCnt <= w_nextTrainCnt;
      r_active   <= (w_nextState != ST_OFF);
      r_valid    <= w_nextValid;
      r_data     <= w_nextData;
    end
  end

  assign tx_active  = r_active;
  assign tx_valid   = r_valid;
  assign tx_data    = r_data;
  assign link_state = r_state;

`ifdef PHY_TX_SCHED_STATS_EN
  logic [15:0] r_cnt0, r_cnt1;

  // Grants only occur in RUN, so the counters naturally hold while OFF.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      r_cnt0 <= 16'd0;
      r_cnt1 <= 16'd0;
    end else begin
      if (w_gnt[0]) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_gnt[1]) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_phy_tx_sched.sv
// Self-checking bench for phy_tx_sched: vector table with a tx-output scoreboard,
// plus hand-written reset, link-drop and async-reset sequences.
module tb_phy_tx_sched;
  import phy_tx_pkg::*;

  localparam logic [31:0] TW   = 32'hBCBCBCBC;
  localparam logic [31:0] IW   = 32'h00000000;
  localparam logic [31:0] WA   = 32'hAAAA1234;
  localparam logic [31:0] WB   = 32'h12345678;
  localparam logic [31:0] WD   = 32'hBBBBAAAA;
  localparam logic [1:0]  SOFF = 2'b00;
  localparam logic [1:0]  STRN = 2'b01;
  localparam logic [1:0]  SRUN = 2'b10;

  logic        clk_f   = 1'b0;
  logic        reset   = 1'b0;
  logic        link_en = 1'b0;
  logic        req0    = 1'b0;
  logic        req1    = 1'b0;
  logic [31:0] data0   = '0;
  logic [31:0] data1   = '0;
  logic        gnt0, gnt1, tx_active, tx_valid;
  logic [31:0] tx_data;
  logic [1:0]  link_state;
`ifdef PHY_TX_SCHED_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif

  int checks    = 0;
  int errors    = 0;
  int modelCnt0 = 0;
  int modelCnt1 = 0;

  typedef struct {
    logic        le;
    logic        r0;
    logic [31:0] d0;
    logic        r1;
    logic [31:0] d1;
    logic        g0;
    logic        g1;
    logic        v;
    logic [31:0] d;
    logic [1:0]  st;
    logic        act;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [1:0]  st;
    logic        act;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  phy_tx_sched dut (
    .clk_f      (clk_f),
    .reset      (reset),
    .link_en    (link_en),
    .req0       (req0),
    .data0      (data0),
    .gnt0       (gnt0),
    .req1       (req1),
    .data1      (data1),
    .gnt1       (gnt1),
    .tx_active  (tx_active),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .link_state (link_state)
`ifdef PHY_TX_SCHED_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  initial forever #5 clk_f = ~clk_f;

  function automatic vec_t mkVec(input logic le, input logic r0, input logic [31:0] d0,
                                 input logic r1, input logic [31:0] d1,
                                 input logic g0, input logic g1,
                                 input logic v, input logic [31:0] d,
                                 input logic [1:0] st, input logic act);
    vec_t x;
    x.le = le; x.r0 = r0; x.d0 = d0; x.r1 = r1; x.d1 = d1;
    x.g0 = g0; x.g1 = g1; x.v = v; x.d = d; x.st = st; x.act = act;
    return x;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Drive one vector on the falling edge, check the combinational grants and
  // queue the tx outputs expected after the following rising edge.
  task automatic applyStimulus(input vec_t x, input int idx);
    exp_t e;
    @(negedge clk_f);
    link_en = x.le; req0 = x.r0; data0 = x.d0; req1 = x.r1; data1 = x.d1;
    #1;
    checkVal($sformatf("gnt0[%0d]", idx), {31'd0, gnt0}, {31'd0, x.g0});
    checkVal($sformatf("gnt1[%0d]", idx), {31'd0, gnt1}, {31'd0, x.g1});
    checks++;
    if (gnt0 && gnt1) begin
      errors++;
      $display("[TB] FAIL dual_gnt[%0d] actual=11 required=not both", idx);
    end
    if (x.g0) modelCnt0++;
    if (x.g1) modelCnt1++;
    e.v = x.v; e.d = x.d; e.st = x.st; e.act = x.act;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    @(posedge clk_f);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty[%0d] actual=0 required=1 entry", idx);
    end else begin
      e = sb.pop_front();
      checkVal($sformatf("tx_valid[%0d]", idx),   {31'd0, tx_valid},  {31'd0, e.v});
      checkVal($sformatf("tx_data[%0d]", idx),    tx_data,            e.d);
      checkVal($sformatf("link_state[%0d]", idx), {30'd0, link_state}, {30'd0, e.st});
      checkVal($sformatf("tx_active[%0d]", idx),  {31'd0, tx_active}, {31'd0, e.act});
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, "_state"},  {30'd0, link_state}, {30'd0, SOFF});
    checkVal({tag, "_active"}, {31'd0, tx_active},  32'd0);
    checkVal({tag, "_valid"},  {31'd0, tx_valid},   32'd0);
    checkVal({tag, "_data"},   tx_data,             IW);
    checkVal({tag, "_gnt0"},   {31'd0, gnt0},       32'd0);
    checkVal({tag, "_gnt1"},   {31'd0, gnt1},       32'd0);
  endtask

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    // Bring-up, single requester, contention, early handoff, link drop and retrain.
    vecs.push_back(mkVec(1, 0, IW,           0, IW, 0, 0, 1, TW, STRN, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkVec(1, 1, 32'hFFFFEEEE, 0, IW, 0, 0, 1, TW, STRN, 1));
    vecs.push_back(mkVec(1, 1, 32'hFFFFEEEE, 0, IW, 0, 0, 0, IW, SRUN, 1));
    vecs.push_back(mkVec(1, 1, 32'hFFFFEEEE, 0, IW, 1, 0, 1, 32'hFFFFEEEE, SRUN, 1));
    vecs.push_back(mkVec(1, 1, 32'hFFEEEEEE, 0, IW, 1, 0, 1, 32'hFFEEEEEE, SRUN, 1));
    vecs.push_back(mkVec(1, 1, 32'hCCEEEEEE, 0, IW, 1, 0, 1, 32'hCCEEEEEE, SRUN, 1));
    vecs.push_back(mkVec(1, 0, IW,           0, IW, 0, 0, 0, IW, SRUN, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mkVec(1, 1, WA, 1, WB, 1, 0, 1, WA, SRUN, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mkVec(1, 1, WA, 1, WB, 0, 1, 1, WB, SRUN, 1));
    for (int i = 0; i < 2; i++) vecs.push_back(mkVec(1, 1, WA, 1, WB, 1, 0, 1, WA, SRUN, 1));
    vecs.push_back(mkVec(1, 0, WA, 1, WB, 0, 1, 1, WB, SRUN, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mkVec(1, 1, WA, 1, WB, 0, 1, 1, WB, SRUN, 1));
    vecs.push_back(mkVec(1, 1, WA, 1, WB, 1, 0, 1, WA, SRUN, 1));
    for (int i = 0; i < 2; i++) vecs.push_back(mkVec(1, 0, IW, 1, WD, 0, 1, 1, WD, SRUN, 1));
    for (int i = 0; i < 2; i++) vecs.push_back(mkVec(0, 0, IW, 1, WD, 0, 0, 0, IW, SOFF, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mkVec(1, 0, IW, 1, WD, 0, 0, 1, TW, STRN, 1));
    vecs.push_back(mkVec(1, 0, IW, 1, WD, 0, 0, 0, IW, SRUN, 1));
    vecs.push_back(mkVec(1, 1, WA, 1, WB, 1, 0, 1, WA, SRUN, 1));

    // Hold reset for two cycles with a pending request; nothing may be granted.
    reset = 1'b0;
    req0  = 1'b1;
    data0 = WA;
    repeat (2) @(posedge clk_f);
    #1;
    checkResetValues("reset");
    @(negedge clk_f);
    reset = 1'b1;
    req0  = 1'b0;
    @(posedge clk_f);
    #1;
    checkVal("post_reset_state", {30'd0, link_state}, {30'd0, SOFF});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], i);
      checkOutput(i);
    end

`ifdef PHY_TX_SCHED_STATS_EN
    checkVal("cnt0_total", {16'd0, cnt0}, 32'(modelCnt0));
    checkVal("cnt1_total", {16'd0, cnt1}, 32'(modelCnt1));
`endif

    // Drop the link, retrain, then pulse reset between edges mid-TRAIN.
    @(negedge clk_f);
    link_en = 1'b0; req0 = 1'b1; req1 = 1'b0;
    @(posedge clk_f);
    @(negedge clk_f);
    link_en = 1'b1;
    @(posedge clk_f);
    #1;
    checkVal("retrain_state", {30'd0, link_state}, {30'd0, STRN});
    checkVal("retrain_data",  tx_data, TW);
    @(posedge clk_f);
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("async_reset");
`ifdef PHY_TX_SCHED_STATS_EN
    checkVal("async_cnt0", {16'd0, cnt0}, 32'd0);
    checkVal("async_cnt1", {16'd0, cnt1}, 32'd0);
`endif
    @(negedge clk_f);
    link_en = 1'b0;
    reset   = 1'b1;
    @(posedge clk_f);
    #1;
    checkVal("after_reset_valid", {31'd0, tx_valid}, 32'd0);
    checkVal("after_reset_state", {30'd0, link_state}, {30'd0, SOFF});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
